// File: rtl/smem_bck_pkg.sv
// Shared widths, status codes and context/entry types for the SMEM backward-extension stage 1.
package smem_bck_pkg;

    localparam int unsigned BCK_READ_NUM_W = 8;
    localparam int unsigned BCK_ADDR_W     = 7;
    localparam int unsigned BCK_CNT_W      = 64;
    localparam int unsigned BCK_INFO_W     = 32;
    localparam int unsigned BCK_DEPTH      = 101;
    localparam int unsigned BCK_PINFO_W    = 2 * BCK_INFO_W;

    localparam logic [5:0] ST_BUBBLE  = 6'd0;
    localparam logic [5:0] ST_F_INIT  = 6'd1;
    localparam logic [5:0] ST_F_RUN   = 6'd2;
    localparam logic [5:0] ST_F_BREAK = 6'd4;
    localparam logic [5:0] ST_BCK_INI = 6'd8;
    localparam logic [5:0] ST_BCK_RUN = 6'd16;
    localparam logic [5:0] ST_BCK_END = 6'd32;

    typedef struct packed {
        logic [5:0]                status;
        logic [BCK_READ_NUM_W-1:0] read_num;
        logic [BCK_ADDR_W-1:0]     backward_x;
        logic [BCK_ADDR_W-1:0]     primary;
        logic [BCK_CNT_W-1:0]      ok_x0;
        logic [BCK_CNT_W-1:0]      ok_x1;
        logic [BCK_CNT_W-1:0]      ok_x2;
        logic [BCK_CNT_W-1:0]      p_x0;
        logic [BCK_CNT_W-1:0]      p_x1;
        logic [BCK_CNT_W-1:0]      p_x2;
        logic [BCK_PINFO_W-1:0]    p_info;
        logic [BCK_CNT_W-1:0]      min_intv;
        logic                      iter_bound;
        logic [BCK_ADDR_W-1:0]     bi;
        logic [BCK_ADDR_W-1:0]     bj;
        logic [BCK_ADDR_W-1:0]     cur_wr_addr;
        logic [BCK_ADDR_W-1:0]     cur_rd_addr;
        logic [BCK_ADDR_W-1:0]     mem_wr_addr;
        logic [BCK_ADDR_W-1:0]     new_size;
        logic [BCK_ADDR_W-1:0]     new_last_size;
        logic [BCK_ADDR_W-1:0]     fwd_size;
        logic [BCK_ADDR_W-1:0]     last_mem_info;
        logic [BCK_CNT_W-1:0]      last_x2;
        logic [BCK_ADDR_W-1:0]     c;
    } bck_ctx_t;

    typedef struct packed {
        logic [BCK_CNT_W-1:0]   x0;
        logic [BCK_CNT_W-1:0]   x1;
        logic [BCK_CNT_W-1:0]   x2;
        logic [BCK_PINFO_W-1:0] info;
    } bck_ent_t;

    // Pointer steps wrap modulo 2^BCK_ADDR_W.
    function automatic logic [BCK_ADDR_W-1:0] addr_inc(input logic [BCK_ADDR_W-1:0] a);
        return a + BCK_ADDR_W'(1);
    endfunction

    function automatic logic [BCK_ADDR_W-1:0] addr_dec(input logic [BCK_ADDR_W-1:0] a);
        return a - BCK_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/smem_bck_ctrl_stage1_hs_decide.sv
// Combinational stage-1 decision: store selection, saturation and the next context.
module smem_bck_decide
    import smem_bck_pkg::*;
#(
    parameter int unsigned ADDR_W = BCK_ADDR_W,
    parameter int unsigned INFO_W = BCK_INFO_W,
    parameter int unsigned DEPTH  = BCK_DEPTH
)(
    input  bck_ctx_t          ctx_i,
    output bck_ctx_t          ctx_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output bck_ent_t          mem_ent_o,
    output logic              curr_we_o,
    output logic [ADDR_W-1:0] curr_addr_o,
    output bck_ent_t          curr_ent_o,
    output logic              last_one_o,
    output logic              mem_sat_o,
    output logic              curr_sat_o
);

    localparam logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(DEPTH - 1);

    logic              amb_s;
    logic              brk_s;
    logic              cond1_s;
    logic              cond2_s;
    logic              j_bound_s;
    logic [ADDR_W-1:0] new_i_s;

    // Decode the incoming context into stores and the context handed to stage 2.
    always_comb begin
        amb_s     = ctx_i.c >= ADDR_W'(4);
        new_i_s   = ctx_i.iter_bound ? '0 : addr_inc(ctx_i.bi);
        brk_s     = amb_s || ctx_i.iter_bound || (ctx_i.ok_x2 < ctx_i.min_intv);
        cond1_s   = brk_s && (ctx_i.new_size == '0)
                    && ((ctx_i.mem_wr_addr == '0) || (new_i_s < ctx_i.last_mem_info));
        cond2_s   = !brk_s && ((ctx_i.new_size == '0) || (ctx_i.ok_x2 != ctx_i.last_x2));
        j_bound_s = ctx_i.bj == addr_dec(ctx_i.new_last_size);

        ctx_o       = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_ent_o   = '0;
        curr_we_o   = 1'b0;
        curr_addr_o = '0;
        curr_ent_o  = '0;
        last_one_o  = 1'b0;
        mem_sat_o   = 1'b0;
        curr_sat_o  = 1'b0;

        case (ctx_i.status)
            ST_BCK_INI: begin
                ctx_o               = ctx_i;
                ctx_o.cur_rd_addr   = addr_dec(ctx_i.fwd_size);
                ctx_o.cur_wr_addr   = addr_dec(ctx_i.fwd_size);
                ctx_o.bj            = '0;
                ctx_o.new_last_size = ctx_i.fwd_size;
                ctx_o.new_size      = '0;
                ctx_o.mem_wr_addr   = '0;
                ctx_o.last_x2       = '0;
                ctx_o.last_mem_info = '0;
                if (ctx_i.backward_x == '0) begin
                    ctx_o.bi         = '0;
                    ctx_o.iter_bound = 1'b1;
                    ctx_o.c          = '0;
                end else begin
                    ctx_o.bi         = addr_dec(ctx_i.backward_x);
                    ctx_o.iter_bound = 1'b0;
                    ctx_o.c          = addr_dec(ctx_i.backward_x);
                end
            end
            ST_BCK_RUN: begin
                ctx_o             = ctx_i;
                ctx_o.c           = ctx_i.bi;
                ctx_o.cur_rd_addr = j_bound_s ? addr_dec(ctx_i.fwd_size) : addr_dec(ctx_i.cur_rd_addr);
                if (cond1_s) begin
                    mem_we_o            = 1'b1;
                    mem_addr_o          = ctx_i.mem_wr_addr;
                    mem_ent_o.x0        = ctx_i.p_x0;
                    mem_ent_o.x1        = ctx_i.p_x1;
                    mem_ent_o.x2        = ctx_i.p_x2;
                    mem_ent_o.info      = {INFO_W'(new_i_s), ctx_i.p_info[INFO_W-1:0]};
                    ctx_o.last_mem_info = new_i_s;
                    // The last MEM slot is rewritten rather than overrun.
                    if (ctx_i.mem_wr_addr == MEM_LAST) begin
                        mem_sat_o = 1'b1;
                    end else begin
                        ctx_o.mem_wr_addr = addr_inc(ctx_i.mem_wr_addr);
                    end
                end else begin
                    mem_we_o = 1'b0;
                end
                if (cond2_s) begin
                    curr_we_o       = 1'b1;
                    curr_addr_o     = ctx_i.cur_wr_addr;
                    curr_ent_o.x0   = ctx_i.ok_x0;
                    curr_ent_o.x1   = ctx_i.ok_x1;
                    curr_ent_o.x2   = ctx_i.ok_x2;
                    curr_ent_o.info = ctx_i.p_info;
                    ctx_o.new_size  = addr_inc(ctx_i.new_size);
                    ctx_o.last_x2   = ctx_i.ok_x2;
                    if (ctx_i.cur_wr_addr == '0) begin
                        curr_sat_o = 1'b1;
                    end else begin
                        ctx_o.cur_wr_addr = addr_dec(ctx_i.cur_wr_addr);
                    end
                end else begin
                    curr_we_o = 1'b0;
                end
                last_one_o = (ctx_i.new_size == '0) && cond2_s && j_bound_s;
            end
            ST_BUBBLE, ST_F_INIT, ST_F_RUN, ST_F_BREAK, ST_BCK_END: begin
                ctx_o = '0;
            end
            default: begin
                ctx_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/smem_bck_ctrl_stage1_hs.sv
// Backward-extension stage 1 with valid/ready flow control, single-shot store strobes and sticky overflow flags.
module smem_bck_ctrl_stage1_hs
    import smem_bck_pkg::*;
#(
    parameter int unsigned READ_NUM_W = BCK_READ_NUM_W,
    parameter int unsigned ADDR_W     = BCK_ADDR_W,
    parameter int unsigned CNT_W      = BCK_CNT_W,
    parameter int unsigned INFO_W     = BCK_INFO_W,
    parameter int unsigned DEPTH      = BCK_DEPTH
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  bck_ctx_t          in_ctx,
    output logic              out_valid,
    input  logic              out_ready,
    output bck_ctx_t          out_ctx,
    output logic              last_one,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output bck_ent_t          mem_data,
    output logic              curr_we,
    output logic [ADDR_W-1:0] curr_addr,
    output bck_ent_t          curr_data,
    output logic              mem_ovf,
    output logic              curr_ovf
);

    // The context types come from the package, so the module parameters must agree with it.
    if ((READ_NUM_W != BCK_READ_NUM_W) || (ADDR_W != BCK_ADDR_W) || (CNT_W != BCK_CNT_W)
        || (INFO_W != BCK_INFO_W) || (DEPTH == 0) || (DEPTH > (1 << ADDR_W))) begin : g_cfg_check
        $error("smem_bck_ctrl_stage1_hs: parameters inconsistent with smem_bck_pkg");
    end

    bck_ctx_t          dec_ctx_s;
    logic              dec_mem_we_s;
    logic [ADDR_W-1:0] dec_mem_addr_s;
    bck_ent_t          dec_mem_ent_s;
    logic              dec_curr_we_s;
    logic [ADDR_W-1:0] dec_curr_addr_s;
    bck_ent_t          dec_curr_ent_s;
    logic              dec_last_one_s;
    logic              dec_mem_sat_s;
    logic              dec_curr_sat_s;
    logic              accept_s;

    logic              out_valid_q, out_valid_d;
    bck_ctx_t          ctx_q, ctx_d;
    logic              last_one_q, last_one_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    bck_ent_t          mem_data_q, mem_data_d;
    logic              curr_we_q, curr_we_d;
    logic [ADDR_W-1:0] curr_addr_q, curr_addr_d;
    bck_ent_t          curr_data_q, curr_data_d;
    logic              mem_ovf_q, mem_ovf_d;
    logic              curr_ovf_q, curr_ovf_d;

    smem_bck_decide #(
        .ADDR_W (ADDR_W),
        .INFO_W (INFO_W),
        .DEPTH  (DEPTH)
    ) u_decide (
        .ctx_i       (in_ctx),
        .ctx_o       (dec_ctx_s),
        .mem_we_o    (dec_mem_we_s),
        .mem_addr_o  (dec_mem_addr_s),
        .mem_ent_o   (dec_mem_ent_s),
        .curr_we_o   (dec_curr_we_s),
        .curr_addr_o (dec_curr_addr_s),
        .curr_ent_o  (dec_curr_ent_s),
        .last_one_o  (dec_last_one_s),
        .mem_sat_o   (dec_mem_sat_s),
        .curr_sat_o  (dec_curr_sat_s)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Next-state: load on accept, drop valid on drain, otherwise hold; strobes fire only on accept.
    always_comb begin
        out_valid_d = out_valid_q;
        ctx_d       = ctx_q;
        last_one_d  = last_one_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        curr_we_d   = 1'b0;
        curr_addr_d = curr_addr_q;
        curr_data_d = curr_data_q;
        mem_ovf_d   = mem_ovf_q;
        curr_ovf_d  = curr_ovf_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            ctx_d       = dec_ctx_s;
            last_one_d  = dec_last_one_s;
            mem_ovf_d   = mem_ovf_q || dec_mem_sat_s;
            curr_ovf_d  = curr_ovf_q || dec_curr_sat_s;
            if (dec_mem_we_s) begin
                mem_we_d   = 1'b1;
                mem_addr_d = dec_mem_addr_s;
                mem_data_d = dec_mem_ent_s;
            end else begin
                mem_we_d   = 1'b0;
            end
            if (dec_curr_we_s) begin
                curr_we_d   = 1'b1;
                curr_addr_d = dec_curr_addr_s;
                curr_data_d = dec_curr_ent_s;
            end else begin
                curr_we_d   = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            last_one_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            ctx_q       <= '0;
            last_one_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            curr_we_q   <= 1'b0;
            curr_addr_q <= '0;
            curr_data_q <= '0;
            mem_ovf_q   <= 1'b0;
            curr_ovf_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ctx_q       <= ctx_d;
            last_one_q  <= last_one_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            curr_we_q   <= curr_we_d;
            curr_addr_q <= curr_addr_d;
            curr_data_q <= curr_data_d;
            mem_ovf_q   <= mem_ovf_d;
            curr_ovf_q  <= curr_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctx   = ctx_q;
    assign last_one  = last_one_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign curr_we   = curr_we_q;
    assign curr_addr = curr_addr_q;
    assign curr_data = curr_data_q;
    assign mem_ovf   = mem_ovf_q;
    assign curr_ovf  = curr_ovf_q;

endmodule
